// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable divider producing a period tick and a divided square wave.
// Newly written divisors wait in a shadow register until the next period boundary or a restart.
module clk_div_prog #(
    parameter int          CNT_WIDTH   = 27,
    parameter int unsigned DIV_DEFAULT = 100_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_restart,
    input  logic                 i_div_wr,
    input  logic [CNT_WIDTH-1:0] i_div_val,
    output logic                 o_tick,
    output logic                 clk_o,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic [CNT_WIDTH-1:0] o_div,
    output logic                 o_pend,
    output logic                 o_div_err
);
    logic [CNT_WIDTH-1:0] r_cnt, r_div, r_shadow;
    logic                 r_pend, r_tick, r_clk, r_err;
    logic [CNT_WIDTH-1:0] w_last, w_half, w_cnt_next, w_div_next;
    logic                 w_wrap, w_wr_ok, w_apply;

    always_comb begin
        w_last     = r_div - CNT_WIDTH'(1);
        w_half     = r_div - (r_div >> 1);
        w_wrap     = i_en && (r_cnt == w_last);
        w_wr_ok    = i_div_wr && (i_div_val != '0);
        w_apply    = i_restart || w_wrap;
        w_cnt_next = w_apply ? '0 : i_en ? r_cnt + CNT_WIDTH'(1) : r_cnt;
        // A write landing on a boundary bypasses the shadow and takes effect immediately
        w_div_next = w_wr_ok ? i_div_val : r_pend ? r_shadow : r_div;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_div    <= CNT_WIDTH'(DIV_DEFAULT);
            r_shadow <= '0;
            r_pend   <= 1'b0;
            r_tick   <= 1'b0;
            r_clk    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tick <= w_wrap && !i_restart;
            r_err  <= i_div_wr && (i_div_val == '0);
            if (i_restart)
                r_clk <= 1'b0;
            else if (i_en)
                r_clk <= w_cnt_next >= w_half;
            if (w_apply) begin
                r_div  <= w_div_next;
                r_pend <= 1'b0;
            end else if (w_wr_ok) begin
                r_shadow <= i_div_val;
                r_pend   <= 1'b1;
            end
        end
    end

    assign o_tick    = r_tick;
    assign clk_o     = r_clk;
    assign o_cnt     = r_cnt;
    assign o_div     = r_div;
    assign o_pend    = r_pend;
    assign o_div_err = r_err;
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed and randomized checks of clk_div_prog against a cycle-level reference model.
module tb_clk_div_prog;
    localparam int W   = 8;
    localparam int DEF = 4;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_en = 1'b0;
    logic         i_restart = 1'b0;
    logic         i_div_wr = 1'b0;
    logic [W-1:0] i_div_val = '0;
    logic         o_tick, clk_o, o_pend, o_div_err;
    logic [W-1:0] o_cnt, o_div;

    int n_checks = 0;
    int n_errors = 0;
    int m_cnt, m_div, m_shadow, m_pend, m_tick, m_clk, m_err;

    clk_div_prog #(.CNT_WIDTH(W), .DIV_DEFAULT(DEF)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_restart(i_restart),
        .i_div_wr(i_div_wr), .i_div_val(i_div_val), .o_tick(o_tick), .clk_o(clk_o),
        .o_cnt(o_cnt), .o_div(o_div), .o_pend(o_pend), .o_div_err(o_div_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: one system-clock edge expressed with plain integer arithmetic
    task automatic model_step();
        int wrap, ok, val;
        val = int'(i_div_val);
        if (i_rst) begin
            m_cnt = 0; m_div = DEF; m_shadow = 0; m_pend = 0;
            m_tick = 0; m_clk = 0; m_err = 0;
            return;
        end
        wrap  = (i_en && m_cnt == m_div - 1) ? 1 : 0;
        ok    = (i_div_wr && val != 0) ? 1 : 0;
        m_err = (i_div_wr && val == 0) ? 1 : 0;
        if (i_restart || wrap) begin
            if (ok) m_div = val;
            else if (m_pend) m_div = m_shadow;
            m_pend = 0;
            m_cnt  = 0;
            m_clk  = 0;
            m_tick = i_restart ? 0 : 1;
        end else begin
            if (ok) begin
                m_shadow = val;
                m_pend   = 1;
            end
            m_tick = 0;
            if (i_en) begin
                m_cnt = m_cnt + 1;
                m_clk = (m_cnt >= (m_div + 1) / 2) ? 1 : 0;
            end
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic restart,
                        input logic wr, input logic [W-1:0] val);
        i_rst = rst; i_en = en; i_restart = restart; i_div_wr = wr; i_div_val = val;
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        check("cnt", int'(o_cnt), m_cnt);
        check("div", int'(o_div), m_div);
        check("pend", int'(o_pend), m_pend);
        check("tick", int'(o_tick), m_tick);
        check("clk_o", int'(clk_o), m_clk);
        check("div_err", int'(o_div_err), m_err);
    endtask

    initial begin
        int first, n_ticks, wait_n;
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check("rst_cnt", int'(o_cnt), 0);
        check("rst_div", int'(o_div), DEF);
        check("rst_tick", int'(o_tick), 0);
        check("rst_clk", int'(clk_o), 0);
        first = 0; n_ticks = 0;
        for (int i = 1; i <= 12; i++) begin
            step(0, 1, 0, 0, 0);
            if (o_tick) begin
                n_ticks++;
                if (first == 0) first = i;
            end
        end
        check("first_tick", first, 4);
        check("ticks_in_12", n_ticks, 3);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 6);
        check("pend_set", int'(o_pend), 1);
        check("div_held", int'(o_div), 4);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("div_applied", int'(o_div), 6);
        check("wrap_tick", int'(o_tick), 1);
        step(0, 1, 0, 1, 0);
        check("err_pulse", int'(o_div_err), 1);
        check("err_div_kept", int'(o_div), 6);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 8);
        check("restart_direct", int'(o_div), 8);
        step(0, 1, 0, 1, 3);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("pre_restart_cnt", int'(o_cnt), 3);
        step(0, 1, 1, 0, 0);
        check("restart_cnt", int'(o_cnt), 0);
        check("restart_div", int'(o_div), 3);
        check("restart_notick", int'(o_tick), 0);
        wait_n = 0;
        for (int i = 1; i <= 10 && wait_n == 0; i++) begin
            step(0, 1, 0, 0, 0);
            if (o_tick) wait_n = i;
        end
        check("restart_to_tick", wait_n, 3);
        step(0, 1, 0, 1, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);
        check("d1_tick", int'(o_tick), 1);
        check("d1_clk", int'(clk_o), 0);
        step(0, 1, 0, 1, 5);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check("midrst_div", int'(o_div), DEF);
        for (int i = 0; i < 3000; i++)
            step(($urandom % 300) == 0, ($urandom % 8) != 0, ($urandom % 40) == 0,
                 ($urandom % 10) == 0, W'($urandom_range(0, 12)));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
